// File: rtl/mux_rr_arb_pkg.sv
// Package mux_rr_pkg: shared defaults and encodings for the mux_rr_arb block.
//   DEF_N / DEF_WIDTH / DEF_CNT_W : default channel count, data width, counter width
//   sel_w(n)                      : index width needed to address n channels
//   st_e                          : output-register occupancy state (EMPTY / FULL)
package mux_rr_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } st_e;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req     in  N      request vector
//   ptr     in  SEL_W  highest-priority index this cycle
//   gnt     out N      one-hot grant (zero when no request)
//   gnt_idx out SEL_W  index of the granted request (0 when none)
//   any     out 1      at least one request present
// N must be a power of two so that ptr + k wraps naturally modulo N.
module rr_pick
  import mux_rr_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [SEL_W-1:0] idx_s;

  // Walk ptr, ptr+1, ... (mod N) and take the first requesting channel.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx_s   = ptr;
    for (int k = 0; k < N; k++) begin
      idx_s = ptr + SEL_W'(k);
      if (!any && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        any        = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-to-1 round-robin multiplexer with valid/ready handshake and a
// registered output stage tagged with the source channel index.
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   N        channel i holds a word
//   in_ready   out  N        channel i word accepted this cycle (one-hot or zero)
//   in_data    in   N*WIDTH  channel i data at [i*WIDTH +: WIDTH]
//   out_valid  out  1        output register holds a word
//   out_ready  in   1        downstream accepts the word
//   out_data   out  WIDTH    registered data
//   out_sel    out  SEL_W    source channel of out_data
//   grant_cnt  out  N*CNT_W  per-channel saturating accepted-word count
// Optional feature macro: MUX_RR_STATS_EN adds the CNT_W parameter, the
// grant_cnt port and the per-channel counters; without it they are absent.
module mux_rr_arb
  import mux_rr_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = sel_w(N)
`ifdef MUX_RR_STATS_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel
`ifdef MUX_RR_STATS_EN
  ,
  output logic [N*CNT_W-1:0] grant_cnt
`endif
);

  st_e              state_r;
  st_e              state_nxt_s;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_sel_r;
  logic [SEL_W-1:0] rr_ptr_r;

  logic [N-1:0]     gnt_s;
  logic [SEL_W-1:0] gnt_idx_s;
  logic             any_s;
  logic             can_load_s;
  logic             load_s;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (any_s)
  );

  // Handshake: the register may load when empty or being drained this cycle.
  // in_ready is forced low while reset is asserted, since the empty register
  // would otherwise advertise a grant during reset.
  always_comb begin
    can_load_s = (state_r == ST_EMPTY) | out_ready;
    load_s     = can_load_s & any_s;
    if (load_s && rst_n) begin
      in_ready = gnt_s;
    end else begin
      in_ready = '0;
    end
  end

  // Next-state logic for the output register occupancy.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          state_nxt_s = ST_FULL;
        end else if (out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output word, source tag and pointer; all change only on a grant so a
  // drained word leaves data/sel holding their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= '0;
      out_sel_r  <= '0;
      rr_ptr_r   <= '0;
    end else if (load_s) begin
      out_data_r <= in_data[gnt_idx_s*WIDTH +: WIDTH];
      out_sel_r  <= gnt_idx_s;
      rr_ptr_r   <= gnt_idx_s + {{(SEL_W-1){1'b0}}, 1'b1};
    end else begin
      out_data_r <= out_data_r;
      out_sel_r  <= out_sel_r;
      rr_ptr_r   <= rr_ptr_r;
    end
  end

  assign out_valid = (state_r == ST_FULL);
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

`ifdef MUX_RR_STATS_EN
  logic [CNT_W-1:0] cnt_r [N];

  // Per-channel accepted-word counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_ready[i] && in_valid[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed, table-driven bench for mux_rr_arb (N=4, WIDTH=8).
module tb_mux_rr_arb;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;
`ifdef MUX_RR_STATS_EN
  localparam int CNT_W = 4;
`endif

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
`ifdef MUX_RR_STATS_EN
  logic [N*CNT_W-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arb #(
    .N     (N),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
`ifdef MUX_RR_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef MUX_RR_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_os;
  } vec_t;

  vec_t tv [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] DSEQ = 32'h1312_1110;

  initial begin
    // Comments track the expected pointer after each vector.
    tv[0]  = '{4'b0100, 32'h13A5_1110, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2}; // ptr 3
    tv[1]  = '{4'b0000, DSEQ,          1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2}; // drain, hold
    tv[2]  = '{4'b1000, DSEQ,          1'b1, 4'b1000, 1'b1, 8'h13, 2'd3}; // ptr 0
    tv[3]  = '{4'b1111, DSEQ,          1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[4]  = '{4'b1111, DSEQ,          1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tv[5]  = '{4'b1111, DSEQ,          1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tv[6]  = '{4'b1111, DSEQ,          1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tv[7]  = '{4'b1111, DSEQ,          1'b1, 4'b0001, 1'b1, 8'h10, 2'd0}; // ptr 1
    tv[8]  = '{4'b1001, DSEQ,          1'b1, 4'b1000, 1'b1, 8'h13, 2'd3}; // skip to 3, ptr 0
    tv[9]  = '{4'b0110, DSEQ,          1'b1, 4'b0010, 1'b1, 8'h11, 2'd1}; // ptr 2
    tv[10] = '{4'b1111, DSEQ,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1}; // backpressure x5
    tv[11] = '{4'b1111, DSEQ,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tv[12] = '{4'b1111, DSEQ,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tv[13] = '{4'b1111, DSEQ,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tv[14] = '{4'b1111, DSEQ,          1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tv[15] = '{4'b1111, DSEQ,          1'b1, 4'b0100, 1'b1, 8'h12, 2'd2}; // release, ptr 3
    tv[16] = '{4'b0000, DSEQ,          1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tv[17] = '{4'b0001, DSEQ,          1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tv[18] = '{4'b0001, DSEQ,          1'b1, 4'b0001, 1'b1, 8'h10, 2'd0}; // ptr 1
    tv[19] = '{4'b0000, DSEQ,          1'b1, 4'b0000, 1'b0, 8'h10, 2'd0}; // drain
    tv[20] = '{4'b0010, 32'hDEAD_BEEF, 1'b0, 4'b0010, 1'b1, 8'hBE, 2'd1}; // load while empty
    tv[21] = '{4'b0000, DSEQ,          1'b0, 4'b0000, 1'b1, 8'hBE, 2'd1};

    // Reset with all channels requesting.
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = DSEQ;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_sel",   32'(out_sel),   32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b0000;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      in_valid  = tv[i].iv;
      in_data   = tv[i].d;
      out_ready = tv[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tv[i].e_ir));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
      check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tv[i].e_od));
      check($sformatf("v%0d_out_sel", i),   32'(out_sel),   32'(tv[i].e_os));
    end

    // Asynchronous reset between edges while FULL: must clear immediately.
    in_valid  = 4'b1111;
    in_data   = DSEQ;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_out_data",  32'(out_data),  32'h0);
    check("arst_out_sel",   32'(out_sel),   32'h0);
    check("arst_in_ready",  32'(in_ready),  32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'h1);
    check("post_rst_out_sel",   32'(out_sel),   32'h0);
    check("post_rst_out_data",  32'(out_data),  32'h10);

`ifdef MUX_RR_STATS_EN
    // Counters: fresh reset, 5 grants to channel 3, then saturation.
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("cnt3_after5", 32'(grant_cnt[12 +: 4]), 32'h5);
    repeat (15) @(negedge clk);
    in_valid = 4'b0000;
    #1;
    check("cnt3_sat", 32'(grant_cnt[12 +: 4]), 32'hF);
    check("cnt0",     32'(grant_cnt[0 +: 4]),  32'h0);
    check("cnt1",     32'(grant_cnt[4 +: 4]),  32'h0);
    check("cnt2",     32'(grant_cnt[8 +: 4]),  32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
